uart_tx_gen2: RTL
=================

Name: uart_tx_gen2

Overview:
Parametrised UART transmitter, the successor to the current fixed 8-bit TX path.
- Adds: configurable data width, a runtime baud prescaler, 1 or 2 stop bits, and a small input FIFO with a valid/ready handshake.
- Back-to-back frames are sent with no idle gap.
- Sits between the system-side byte producer and the serial TX pin, in the same UART TX subsystem as the existing FSM/serializer/parity/mux path.

Parameters:
DATA_WIDTH, 8, payload bits per frame (5..9 supported)
PRESCALE_W, 16, width of the prescale input
FIFO_DEPTH, 4, input FIFO entries (power of 2, >=2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
data  input  DATA_WIDTH  payload word to transmit
data_valid  input  1  producer has a word on data
data_ready  output  1  FIFO can accept; a word transfers on a rising edge where data_valid && data_ready
parity_en  input  1  1 = append parity bit
parity_type  input  1  0 = even, 1 = odd
stop_bits  input  1  0 = one stop bit, 1 = two stop bits
prescale  input  PRESCALE_W  clocks per bit; 0 is treated as 1
out  output  1  serial line, idle high, registered
busy  output  1  high while a frame is on the line
done  output  1  one-cycle pulse at end of each frame
fifo_count  output  $clog2(FIFO_DEPTH)+1  words currently buffered

Behaviour:
- Reset (synchronous, active-high):
  - out=1, busy=0, done=0, data_ready=1, fifo_count=0, FIFO emptied, FSM to IDLE.
  - Reset mid-frame aborts the frame; out is high from the next edge.
- FIFO handshake:
  - data_ready = (fifo_count < FIFO_DEPTH), from registered count.
  - A push while full is not accepted, even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full: count unchanged, both take effect.
- Config sampling:
  - parity_en, parity_type, stop_bits and prescale are latched when the FSM leaves IDLE/STOP into START.
  - Changes mid-frame do not affect the frame in flight.
- Bit timer: counts 0..P-1, where P = max(prescale,1). Each line bit lasts exactly P clocks.
- FSM states and transitions:
  - IDLE: out=1, busy=0. If FIFO non-empty: pop word into shift register, latch config → START.
  - START: out=0 for P clocks → DATA.
  - DATA: out = shift[0], LSB first; shift right each bit; after DATA_WIDTH bits → PARITY if parity_en, else STOP.
  - PARITY: out = XOR of latched word, XOR parity_type; P clocks → STOP.
  - STOP: out=1 for P clocks if stop_bits=0, 2P clocks if stop_bits=1. At the end:
    - done=1 for that one cycle.
    - If FIFO non-empty, pop and go directly to START (no idle cycle); else → IDLE.
- Latency: word accepted at edge E0 with FSM in IDLE and FIFO empty → out falls at edge E1 (out is low for the cycle after acceptance).
- busy: 1 from the START entry edge until the edge that enters IDLE. It stays high across back-to-back frames.
- Frame length: (1 + DATA_WIDTH + parity_en + 1 + stop_bits) * P clocks, measured from out falling to the done pulse edge, inclusive of the final stop bit.
- Parity is computed on the popped word only; FIFO contents never alter the frame in flight.
- fifo_count never exceeds FIFO_DEPTH and never underflows. The pop occurs only in the IDLE/STOP-exit transition.

Test Plan:
1. DATA_WIDTH=8, prescale=4, parity_en=0, stop_bits=0; push 0xA5 → out bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks; done pulses 40 clocks after out falls; busy drops next edge.
2. Same word with parity_en=1, parity_type=0 → parity bit 0, 44-clock frame. Repeat with parity_type=1 → parity bit 1.
3. stop_bits=1, prescale=0 → each bit 1 clock (treated as 1); stop high for 2 clocks; 11-clock frame.
4. Push 0x01, 0x80, 0xFF on consecutive cycles, prescale=2 → three frames with no idle gap (start bit follows the last stop bit immediately); exactly 3 done pulses; busy continuously high.
5. FIFO_DEPTH=4: hold data_valid for 6 consecutive pushes during a frame → 4 accepted, data_ready low while fifo_count=4, rejected words never transmitted; transmitted order matches push order.
6. Assert rst for 1 cycle in the middle of DATA → out=1, busy=0, fifo_count=0 on the next edge; no done pulse; the next push transmits a clean full frame.

Source files
------------

// File: rtl/uart_tx_gen2.sv
`default_nettype none
// ============================================================================
// uart_tx_gen2 : UART transmitter with input FIFO, runtime prescaler,
//                optional parity and one/two stop bits; frames run back to back.
// Revision     : 1.0
// ============================================================================
module uart_tx_gen2 #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         data,
  input  logic                          data_valid,
  output logic                          data_ready,
  input  logic                          parity_en,
  input  logic                          parity_type,
  input  logic                          stop_bits,
  input  logic [PRESCALE_W-1:0]         prescale,
  output logic                          out,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  push;
  logic                  pop;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] rd_word;

  // Transmitter state
  state_t                state_q, state_d;
  logic [PRESCALE_W-1:0] timer_q, timer_d;
  logic [PRESCALE_W-1:0] period_q, period_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  stop2nd_q, stop2nd_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_bit_q, par_bit_d;
  logic                  par_en_q, par_en_d;
  logic                  stop2_q, stop2_d;
  logic                  out_q, out_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  timer_last;
  logic                  start_frame;
  logic [PRESCALE_W-1:0] prescale_eff;

  assign data_ready   = (count_q < CNT_W'(FIFO_DEPTH));
  assign push         = data_valid && data_ready;
  assign fifo_empty   = (count_q == '0);
  assign rd_word      = mem_q[rd_ptr_q];
  assign prescale_eff = (prescale == '0) ? PRESCALE_W'(1) : prescale;
  assign timer_last   = (timer_q == (period_q - PRESCALE_W'(1)));

  assign out        = out_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fifo_count = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    bit_d       = bit_q;
    stop2nd_d   = stop2nd_q;
    shift_d     = shift_q;
    par_bit_d   = par_bit_q;
    par_en_d    = par_en_q;
    stop2_d     = stop2_q;
    out_d       = out_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pop         = 1'b0;
    start_frame = 1'b0;
    timer_d     = (state_q == S_IDLE || timer_last) ? '0 : timer_q + PRESCALE_W'(1);

    case (state_q)
      S_IDLE: begin
        out_d       = 1'b1;
        busy_d      = 1'b0;
        start_frame = !fifo_empty;
      end
      S_START: begin
        if (timer_last) begin
          state_d = S_DATA;
          bit_d   = '0;
          out_d   = shift_q[0];
        end
      end
      S_DATA: begin
        if (timer_last) begin
          if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
            if (par_en_q) begin
              state_d = S_PARITY;
              out_d   = par_bit_q;
            end else begin
              state_d   = S_STOP;
              stop2nd_d = 1'b0;
              out_d     = 1'b1;
            end
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = shift_q >> 1;
            out_d   = shift_d[0];
          end
        end
      end
      S_PARITY: begin
        if (timer_last) begin
          state_d   = S_STOP;
          stop2nd_d = 1'b0;
          out_d     = 1'b1;
        end
      end
      S_STOP: begin
        if (timer_last) begin
          if (stop2_q && !stop2nd_q) begin
            stop2nd_d = 1'b1;
          end else begin
            done_d = 1'b1;
            if (!fifo_empty) begin
              start_frame = 1'b1;
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              out_d   = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        out_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Frame launch: parity is taken from the popped word, config frozen here
    if (start_frame) begin
      pop       = 1'b1;
      shift_d   = rd_word;
      par_bit_d = (^rd_word) ^ parity_type;
      par_en_d  = parity_en;
      stop2_d   = stop_bits;
      period_d  = prescale_eff;
      timer_d   = '0;
      state_d   = S_START;
      out_d     = 1'b0;
      busy_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= S_IDLE;
      timer_q   <= '0;
      period_q  <= PRESCALE_W'(1);
      bit_q     <= '0;
      stop2nd_q <= 1'b0;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
      stop2_q   <= 1'b0;
      out_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      period_q  <= period_d;
      bit_q     <= bit_d;
      stop2nd_q <= stop2nd_d;
      shift_q   <= shift_d;
      par_bit_q <= par_bit_d;
      par_en_q  <= par_en_d;
      stop2_q   <= stop2_d;
      out_q     <= out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= data;
    end
  end

endmodule
`default_nettype wire
